fbuf_arbiter: RTL and testbench

FBUF_ARBITER -- requirements
Module: fbuf_arbiter

---
 rtl/fbuf_pkg.sv | 17 +
 rtl/fbuf_clear_counter.sv | 29 ++
 rtl/fbuf_arbiter.sv | 108 ++++++++++
 tb/tb_fbuf_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fbuf_pkg.sv
// rtl/fbuf_pkg.sv - shared widths, word counts and FSM encoding for the framebuffer arbiter
package fbuf_pkg;
  localparam int FBUF_AW       = 9;
  localparam int FBUF_DW       = 16;
  localparam int FBUF_WORDS_HI = 512;
  localparam int FBUF_WORDS_LO = 128;

  typedef logic [FBUF_AW-1:0] fbuf_addr_t;
  typedef logic [FBUF_DW-1:0] fbuf_word_t;

  localparam fbuf_addr_t FBUF_LAST_HI = fbuf_addr_t'(FBUF_WORDS_HI - 1);
  localparam fbuf_addr_t FBUF_LAST_LO = fbuf_addr_t'(FBUF_WORDS_LO - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CPU_RD = 2'd1;
  localparam logic [1:0] ST_CLEAR  = 2'd2;
endpackage

// File: rtl/fbuf_clear_counter.sv
// rtl/fbuf_clear_counter.sv - clear address counter with a limit captured at start
module fbuf_clear_counter
  import fbuf_pkg::*;
(
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  input  logic       enable,
  input  fbuf_addr_t limit,
  output fbuf_addr_t addr,
  output logic       done
);
  fbuf_addr_t lim_q;

  // The limit is frozen at start so a mode change cannot stretch or cut a running clear.
  always_ff @(posedge clk) begin
    if (!res) begin
      addr  <= '0;
      lim_q <= '0;
    end else if (start) begin
      addr  <= '0;
      lim_q <= limit;
    end else if (enable && !done) begin
      addr <= addr + fbuf_addr_t'(1);
    end
  end

  assign done = (addr == lim_q);
endmodule

// File: rtl/fbuf_arbiter.sv
// rtl/fbuf_arbiter.sv - single-port framebuffer RAM arbiter: display > clear > CPU
module fbuf_arbiter
  import fbuf_pkg::*;
(
  input  logic       clk,
  input  logic       res,
  input  logic       hires,
  input  logic       disp_req,
  input  fbuf_addr_t disp_addr,
  output fbuf_word_t disp_data,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  fbuf_addr_t cpu_addr,
  input  fbuf_word_t cpu_wdata,
  output logic       cpu_ack,
  output fbuf_word_t cpu_rdata,
  input  logic       clr_start,
  output logic       clr_busy,
  output fbuf_addr_t ram_addr,
  output logic       ram_we,
  output fbuf_word_t ram_wdata,
  input  fbuf_word_t ram_rdata
);
  logic [1:0] state;
  logic       disp_pend;
  logic       clr_go;
  logic       clr_wr;
  logic       cpu_go;
  logic       cpu_wr;
  logic       cpu_rd;
  logic       clr_done;
  fbuf_addr_t clr_addr;
  fbuf_addr_t clr_limit;

  assign clr_go    = (state == ST_IDLE) && clr_start;
  // cpu_ack gates the start so a held request is not served twice.
  assign cpu_go    = (state == ST_IDLE) && cpu_req && !disp_req && !clr_start && !cpu_ack;
  assign cpu_wr    = cpu_go && cpu_we;
  assign cpu_rd    = cpu_go && !cpu_we;
  assign clr_wr    = (state == ST_CLEAR) && !disp_req;
  assign clr_limit = hires ? FBUF_LAST_HI : FBUF_LAST_LO;

  fbuf_clear_counter u_clr_cnt (
    .clk    (clk),
    .res    (res),
    .start  (clr_go),
    .enable (clr_wr),
    .limit  (clr_limit),
    .addr   (clr_addr),
    .done   (clr_done)
  );

  always_comb begin
    ram_addr  = cpu_addr;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (disp_req) begin
      ram_addr = disp_addr;
    end else if (clr_wr) begin
      ram_addr = clr_addr;
      ram_we   = res;
    end else if (cpu_wr) begin
      ram_we    = res;
      ram_wdata = cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state     <= ST_IDLE;
      disp_pend <= 1'b0;
      disp_data <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      clr_busy  <= 1'b0;
    end else begin
      disp_pend <= disp_req;
      if (disp_pend) begin
        disp_data <= ram_rdata;
      end
      cpu_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clr_go) begin
            state <= ST_CLEAR;
          end else if (cpu_rd) begin
            state <= ST_CPU_RD;
          end else if (cpu_wr) begin
            cpu_ack <= 1'b1;
          end
        end
        ST_CPU_RD: begin
          cpu_rdata <= ram_rdata;
          cpu_ack   <= 1'b1;
          state     <= ST_IDLE;
        end
        ST_CLEAR: begin
          if (clr_wr && clr_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // Stays high for one extra cycle after the final clear write.
      clr_busy <= clr_go || (state == ST_CLEAR);
    end
  end
endmodule

// File: tb/tb_fbuf_arbiter.sv
// tb/tb_fbuf_arbiter.sv - randomized self-checking bench for fbuf_arbiter
module tb_fbuf_arbiter;
  import fbuf_pkg::*;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        hires = 1'b0;
  logic        disp_req = 1'b0;
  logic [8:0]  disp_addr = '0;
  logic [15:0] disp_data;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [8:0]  cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        clr_start = 1'b0;
  logic        clr_busy;
  logic [8:0]  ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  fbuf_arbiter dut (
    .clk       (clk),
    .res       (res),
    .hires     (hires),
    .disp_req  (disp_req),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench-owned single-port RAM, write-first, preloaded with random words.
  logic [15:0] ram_init [512];
  logic [15:0] ram_mem  [512];
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 512; i++) ram_mem[i] <= ram_init[i];
    end else if (ram_we) begin
      ram_mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= ram_we ? ram_wdata : ram_mem[ram_addr];
  end

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model: expected RAM image plus the pending CPU op, clear and display returns.
  logic [15:0] shadow [512];
  bit          clr_act = 0;
  int          clr_s = 0;
  int          clr_end = -10;
  int          clr_next = 0;
  int          clr_last = 0;
  bit          cpu_pend = 0;
  bit          cpu_issued = 0;
  bit          exp_rd = 0;
  logic        cpu_m_we;
  logic [8:0]  cpu_m_addr;
  logic [15:0] cpu_m_wdata;
  logic [15:0] exp_rdata;
  logic [15:0] disp_exp = '0;
  int          exp_ack = -1;
  int          we_cnt = 0;
  bit          res_prev = 0;
  logic [15:0] dq_val [$];
  int          dq_due [$];

  always @(negedge clk) begin
    if (!res) begin
      check_eq("rst_ram_we", 32'(ram_we), 0);
      clr_act = 0; cpu_pend = 0; cpu_issued = 0; exp_ack = -1; clr_end = -10;
      dq_val.delete(); dq_due.delete(); disp_exp = '0;
    end else begin
      if (!res_prev) check_eq("rst_cpu_rdata", cpu_rdata, 0);
      if (ram_we) we_cnt++;
      if (clr_start && !clr_act) begin
        clr_act = 1; clr_s = cyc; clr_next = 0; clr_last = hires ? 511 : 127;
      end
      check_eq("clr_busy", 32'(clr_busy), 32'((clr_act && cyc > clr_s) || cyc == clr_end + 1));
      check_eq("cpu_ack", 32'(cpu_ack), 32'(cyc == exp_ack));
      if (cyc == exp_ack) begin
        if (exp_rd) check_eq("cpu_rdata", cpu_rdata, exp_rdata);
        cpu_pend = 0;
      end
      if (dq_due.size() > 0 && dq_due[0] == cyc) begin
        disp_exp = dq_val.pop_front();
        void'(dq_due.pop_front());
      end
      check_eq("disp_data", disp_data, disp_exp);
      if (disp_req) begin
        check_eq("disp_ram_addr", ram_addr, disp_addr);
        check_eq("disp_ram_we", 32'(ram_we), 0);
        dq_val.push_back(shadow[disp_addr]);
        dq_due.push_back(cyc + 2);
      end else if (cpu_pend && !cpu_issued && !clr_act) begin
        check_eq("cpu_ram_addr", ram_addr, cpu_m_addr);
        check_eq("cpu_ram_we", 32'(ram_we), 32'(cpu_m_we));
        if (cpu_m_we) begin
          check_eq("cpu_ram_wdata", ram_wdata, cpu_m_wdata);
          shadow[cpu_m_addr] = cpu_m_wdata;
          exp_ack = cyc + 1;
        end else begin
          exp_rdata = shadow[cpu_m_addr];
          exp_ack = cyc + 2;
        end
        exp_rd = !cpu_m_we;
        cpu_issued = 1;
      end else if (clr_act && cyc > clr_s) begin
        check_eq("clr_ram_we", 32'(ram_we), 1);
        check_eq("clr_ram_addr", ram_addr, clr_next);
        check_eq("clr_ram_wdata", ram_wdata, 0);
        shadow[clr_next] = '0;
        if (clr_next == clr_last) begin
          clr_act = 0; clr_end = cyc;
        end else begin
          clr_next++;
        end
      end else begin
        check_eq("idle_ram_we", 32'(ram_we), 0);
      end
    end
    res_prev = res;
  end

  // Display driver: 0 = off, 1 = random 50%, 2 = driven by the main sequence.
  int disp_mode = 0;
  initial forever begin
    @(posedge clk); #1;
    if (disp_mode == 0) disp_req = 1'b0;
    else if (disp_mode == 1) begin
      disp_req  = 1'($urandom_range(0, 1));
      disp_addr = 9'($urandom_range(0, 511));
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  logic ack_busy;

  task automatic cpu_op(input logic we, input logic [8:0] addr, input logic [15:0] wdata);
    int n = 0;
    cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    cpu_m_we = we; cpu_m_addr = addr; cpu_m_wdata = wdata; cpu_issued = 0; cpu_pend = 1;
    do begin @(negedge clk); n++; end while (!cpu_ack && n < 3000);
    if (!cpu_ack) begin
      check_eq("cpu_ack_timeout", 32'(cpu_ack), 1);
      cpu_pend = 0;
    end
    ack_busy = clr_busy;
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic clear_start(input logic hi);
    hires = hi; clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
  endtask

  task automatic wait_clear;
    int n = 0;
    do begin @(negedge clk); n++; end while ((clr_act || clr_busy) && n < 3000);
    check_eq("clear_end_busy", 32'(clr_busy), 0);
    tick();
  endtask

  logic [15:0] v;
  logic [15:0] v128;
  int          w0;
  int          w1;

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram_init[i] = 16'($urandom);
      shadow[i]   = ram_init[i];
    end
    repeat (3) tick();
    res = 1'b1;
    tick();

    // CPU write then a read held off by four display cycles.
    cpu_op(1'b1, 9'd3, 16'h1A5A);
    check_eq("w3_ram", ram_mem[3], 16'h1A5A);
    disp_mode = 2; disp_req = 1'b1; disp_addr = 9'($urandom_range(0, 511));
    fork
      cpu_op(1'b0, 9'd3, 16'h0);
      begin repeat (4) tick(); disp_req = 1'b0; end
    join
    check_eq("rd3_rdata", cpu_rdata, 16'h1A5A);

    // Single display read at addr 7, then hold.
    v = 16'($urandom);
    cpu_op(1'b1, 9'd7, v);
    disp_addr = 9'd7; disp_req = 1'b1;
    tick();
    disp_req = 1'b0;
    tick();
    @(negedge clk);
    check_eq("disp7", disp_data, v);
    repeat (3) tick();
    check_eq("disp7_hold", disp_data, v);

    // Low-res clear under random display traffic; hires flips mid-clear.
    v128 = ram_mem[128];
    w0 = we_cnt;
    disp_mode = 1;
    fork
      begin clear_start(1'b0); wait_clear(); end
      begin repeat (20) tick(); hires = 1'b1; end
    join
    check_eq("clr_lo_count", we_cnt - w0, 128);
    check_eq("clr_lo_127", ram_mem[127], 0);
    check_eq("clr_lo_128_kept", ram_mem[128], v128);

    // High-res clear with a CPU write arriving mid-clear.
    w0 = we_cnt;
    v = 16'($urandom);
    fork
      begin clear_start(1'b1); wait_clear(); end
      begin repeat (100) tick(); cpu_op(1'b1, 9'd200, v); end
    join
    check_eq("clr_hi_count", we_cnt - w0, 513);
    check_eq("ack_after_clear", 32'(ack_busy), 0);
    check_eq("w200_ram", ram_mem[200], v);

    // Clear and CPU read requested together: clear goes first.
    fork
      clear_start(1'b0);
      cpu_op(1'b0, 9'd200, 16'h0);
    join
    wait_clear();
    check_eq("rd200_after_clear", cpu_rdata, v);

    // Reset mid-clear stops all writes.
    disp_mode = 0; disp_req = 1'b0;
    w0 = we_cnt;
    clear_start(1'b1);
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (we_cnt - w0 < 40 && n < 200);
    end
    tick();
    res = 1'b0;
    tick();
    res = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_clear_busy", 32'(clr_busy), 0);
    w1 = we_cnt;
    repeat (20) tick();
    check_eq("no_we_after_rst", we_cnt - w1, 0);

    // Random mix of CPU ops and clears under random display traffic.
    disp_mode = 1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        clear_start(1'($urandom_range(0, 1)));
        wait_clear();
      end else begin
        cpu_op(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), 16'($urandom));
      end
    end
    disp_mode = 0; disp_req = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
